// File: rtl/otter_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : otter_uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter for the Otter MCU IO bus.
//            The CPU pushes bytes into a TX FIFO. The FSM serialises them
//            LSB first, sending frames back to back while data remains.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous reset, active low
//            iobus_addr - byte address from the MCU
//            iobus_out  - write data from the MCU ([7:0] used for TXDATA)
//            iobus_wr   - one-cycle write strobe
//            rd_data    - combinational read data for the iobus_in mux
//            tx         - registered serial output, idle high
//            irq        - registered one-cycle "FIFO drained" pulse
// Register map (offset = iobus_addr[3:2]):
//            0 TXDATA (W)  1 STATUS (R, write clears overflow)
//            2 CTRL (R/W, bit0 irq_en)  3 reserved
// Revision : 1.0 - initial release
// ============================================================================
module otter_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_8000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iobus_addr,
    input  logic [31:0] iobus_out,
    input  logic        iobus_wr,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] C_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] C_DEPTH     = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_START = 2'd1;
    localparam logic [1:0] C_ST_DATA  = 2'd2;
    localparam logic [1:0] C_ST_STOP  = 2'd3;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic       w_hit;
    logic [1:0] w_off;
    logic       w_wr_data;
    logic       w_wr_status;
    logic       w_wr_ctrl;
    logic       w_unused_bits;

    assign w_hit       = (iobus_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off       = iobus_addr[3:2];
    assign w_wr_data   = w_hit && iobus_wr && (w_off == 2'd0);
    assign w_wr_status = w_hit && iobus_wr && (w_off == 2'd1);
    assign w_wr_ctrl   = w_hit && iobus_wr && (w_off == 2'd2);

    // Address byte-lane bits and upper write data have no function here.
    assign w_unused_bits = ^{iobus_addr[1:0], iobus_out[31:8]};

    // ------------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic [7:0]       w_fifo_rd;

    assign w_full    = (count_q == C_DEPTH);
    assign w_empty   = (count_q == '0);
    // Fullness is judged on the registered count, so a same-cycle pop never
    // makes room for a push.
    assign w_push    = w_wr_data && !w_full;
    assign w_drop    = w_wr_data && w_full;
    assign w_fifo_rd = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            mem_q[wr_ptr_q] <= iobus_out[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + LVL_W'(1);
                2'b01:   count_q <= count_q - LVL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control / status registers
    // ------------------------------------------------------------------------
    logic ovf_q;
    logic irq_en_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            // A dropped push takes priority over a STATUS-write clear.
            if (w_drop) begin
                ovf_q <= 1'b1;
            end else if (w_wr_status) begin
                ovf_q <= 1'b0;
            end
            if (w_wr_ctrl) begin
                irq_en_q <= iobus_out[0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // TX FSM: state register
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] baud_q,    baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             tx_q,      tx_d;
    logic             irq_q,     irq_d;
    logic             w_baud_done;

    assign w_baud_done = (baud_q == C_BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= C_ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
        end
    end

    // ------------------------------------------------------------------------
    // TX FSM: next-state logic (also decides when to pop the FIFO)
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        w_pop     = 1'b0;
        case (state_q)
            C_ST_IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_fifo_rd;
                    state_d = C_ST_START;
                end
            end
            C_ST_START: begin
                if (w_baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = C_ST_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            C_ST_DATA: begin
                if (w_baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = C_ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            C_ST_STOP: begin
                if (w_baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next frame without an idle bit.
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        shift_d = w_fifo_rd;
                        state_d = C_ST_START;
                    end else begin
                        state_d = C_ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // TX FSM: output logic (next values of the registered tx / irq)
    // ------------------------------------------------------------------------
    always_comb begin
        tx_d  = tx_q;
        irq_d = 1'b0;
        case (state_q)
            C_ST_IDLE: begin
                // Start bit goes out on the same edge as the pop.
                tx_d = w_empty;
            end
            C_ST_START: begin
                if (w_baud_done) begin
                    tx_d = shift_q[0];
                end
            end
            C_ST_DATA: begin
                if (w_baud_done) begin
                    // shift_q[1] is the bit that becomes shift_q[0] after the shift.
                    tx_d = (bit_idx_q == 3'd7) ? 1'b1 : shift_q[1];
                end
            end
            C_ST_STOP: begin
                if (w_baud_done) begin
                    if (!w_empty) begin
                        tx_d = 1'b0;
                    end else begin
                        tx_d  = 1'b1;
                        irq_d = irq_en_q;
                    end
                end
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    assign tx  = tx_q;
    assign irq = irq_q;

    // ------------------------------------------------------------------------
    // Read mux (no dependency on iobus_wr)
    // ------------------------------------------------------------------------
    logic       w_busy;
    logic [7:0] w_count8;

    assign w_busy   = (state_q != C_ST_IDLE);
    assign w_count8 = 8'(count_q);

    always_comb begin
        rd_data = '0;
        if (w_hit) begin
            case (w_off)
                2'd1:    rd_data = {16'h0000, w_count8, 4'h0, ovf_q, w_empty, w_full, w_busy};
                2'd2:    rd_data = {31'h0, irq_en_q};
                default: rd_data = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_uart_tx
// Purpose  : Directed self-checking bench for otter_uart_tx with
//            CLKS_PER_BIT=4 and an 8-deep FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_uart_tx;

    localparam logic [31:0] C_BASE   = 32'h1100_8000;
    localparam logic [31:0] C_STATUS = 32'h1100_8004;
    localparam logic [31:0] C_CTRL   = 32'h1100_8008;
    localparam logic [31:0] C_RSVD   = 32'h1100_800C;
    localparam int          C_CPB    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] iobus_addr = '0;
    logic [31:0] iobus_out  = '0;
    logic        iobus_wr   = 1'b0;
    logic [31:0] rd_data;
    logic        tx;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;

    otter_uart_tx #(
        .BASE_ADDR   (C_BASE),
        .CLKS_PER_BIT(C_CPB),
        .FIFO_DEPTH  (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .iobus_addr(iobus_addr),
        .iobus_out (iobus_out),
        .iobus_wr  (iobus_wr),
        .rd_data   (rd_data),
        .tx        (tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        iobus_addr = a;
        iobus_out  = d;
        iobus_wr   = 1'b1;
        tick();
        iobus_wr   = 1'b0;
        iobus_addr = '0;
        iobus_out  = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        iobus_addr = a;
        #1;
        v = rd_data;
        iobus_addr = '0;
    endtask

    // Called in the cycle tx has just fallen for the start bit; returns in
    // the cycle right after the stop bit's last sample.
    task automatic expect_frame(input logic [7:0] b);
        logic [9:0]  bits;
        logic [31:0] v;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < C_CPB; j++) begin
                chk($sformatf("frame_%02h_bit%0d_c%0d", b, k, j), {31'h0, tx}, {31'h0, bits[k]});
                if (j == 0) begin
                    chk($sformatf("frame_%02h_irq_bit%0d", b, k), {31'h0, irq}, 32'h0);
                end
                if (k == 5 && j == 0) begin
                    bus_read(C_STATUS, v);
                    chk($sformatf("frame_%02h_busy", b), v & 32'h1, 32'h1);
                end
                tick();
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        logic        stayed_high;

        // ---------------- reset ----------------
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        chk("reset_tx", {31'h0, tx}, 32'h1);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        bus_read(C_STATUS, v);
        chk("reset_status", v, 32'h0000_0004);
        bus_read(C_CTRL, v);
        chk("reset_ctrl", v, 32'h0);

        // ---------------- single frame 0x55 ----------------
        bus_write(C_BASE, 32'h55);
        chk("lat_before_fall", {31'h0, tx}, 32'h1);
        tick();
        expect_frame(8'h55);
        chk("t1_idle_tx", {31'h0, tx}, 32'h1);
        chk("t1_irq_off", {31'h0, irq}, 32'h0);
        bus_read(C_STATUS, v);
        chk("t1_status_after", v, 32'h0000_0004);

        // ---------------- back-to-back frames ----------------
        bus_write(C_BASE, 32'hA0);
        bus_write(C_BASE, 32'h0F);
        bus_read(C_STATUS, v);
        chk("t2_status_cnt1", v, 32'h0000_0101);
        expect_frame(8'hA0);
        expect_frame(8'h0F);
        bus_read(C_STATUS, v);
        chk("t2_status_after", v, 32'h0000_0004);

        // ---------------- FIFO full / overflow ----------------
        for (int i = 0; i < 10; i++) begin
            bus_write(C_BASE, 32'h30 + i);
            if (i == 8) begin
                bus_read(C_STATUS, v);
                chk("t3_status_full", v, 32'h0000_0803);
            end
        end
        bus_read(C_STATUS, v);
        chk("t3_status_ovf", v, 32'h0000_080B);
        bus_write(C_STATUS, 32'hFFFF_FFFF);
        bus_read(C_STATUS, v);
        chk("t3_status_clr", v, 32'h0000_0803);
        // First frame started one edge after the first write; skip to the
        // start of the second frame.
        repeat (31) tick();
        for (int i = 1; i < 9; i++) begin
            expect_frame(8'h30 + 8'(i));
        end
        chk("t3_idle_tx", {31'h0, tx}, 32'h1);
        bus_read(C_STATUS, v);
        chk("t3_status_after", v, 32'h0000_0004);
        stayed_high = 1'b1;
        repeat (12) begin
            tick();
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        chk("t3_dropped_not_sent", {31'h0, stayed_high}, 32'h1);

        // ---------------- irq ----------------
        bus_write(C_CTRL, 32'h0000_0003);
        bus_read(C_CTRL, v);
        chk("t4_ctrl_rd", v, 32'h1);
        bus_write(C_BASE, 32'h3C);
        tick();
        expect_frame(8'h3C);
        chk("t4_irq_pulse", {31'h0, irq}, 32'h1);
        tick();
        chk("t4_irq_one_cycle", {31'h0, irq}, 32'h0);
        bus_write(C_CTRL, 32'h0);
        bus_write(C_BASE, 32'hC3);
        tick();
        expect_frame(8'hC3);
        chk("t4_irq_disabled", {31'h0, irq}, 32'h0);
        tick();
        chk("t4_irq_disabled2", {31'h0, irq}, 32'h0);

        // ---------------- reset mid-frame ----------------
        bus_write(C_CTRL, 32'h1);
        bus_write(C_BASE, 32'h96);
        bus_write(C_BASE, 32'h11);
        bus_write(C_BASE, 32'h22);
        repeat (16) tick();
        chk("t5_data_bit3", {31'h0, tx}, 32'h0);
        rst = 1'b0;
        bus_write(C_BASE, 32'h77);
        chk("t5_rst_tx", {31'h0, tx}, 32'h1);
        chk("t5_rst_irq", {31'h0, irq}, 32'h0);
        bus_read(C_STATUS, v);
        chk("t5_rst_status", v, 32'h0000_0004);
        rst = 1'b1;
        bus_read(C_CTRL, v);
        chk("t5_rst_ctrl", v, 32'h0);
        stayed_high = 1'b1;
        repeat (60) begin
            tick();
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        chk("t5_no_tx_after_rst", {31'h0, stayed_high}, 32'h1);
        bus_read(C_STATUS, v);
        chk("t5_status_after", v, 32'h0000_0004);

        // ---------------- decode misses ----------------
        bus_write(C_BASE + 32'h10, 32'hFF);
        bus_write(32'h0, 32'hFF);
        bus_write(C_RSVD, 32'hFF);
        iobus_addr = C_CTRL;
        iobus_out  = 32'h1;
        iobus_wr   = 1'b0;
        tick();
        iobus_addr = '0;
        iobus_out  = '0;
        stayed_high = 1'b1;
        repeat (8) begin
            tick();
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        chk("t6_tx_idle", {31'h0, stayed_high}, 32'h1);
        bus_read(C_STATUS, v);
        chk("t6_status", v, 32'h0000_0004);
        bus_read(C_CTRL, v);
        chk("t6_ctrl_unchanged", v, 32'h0);
        bus_read(C_RSVD, v);
        chk("t6_rd_rsvd", v, 32'h0);
        bus_read(C_BASE, v);
        chk("t6_rd_txdata", v, 32'h0);
        iobus_addr = C_BASE + 32'h14;
        #1;
        chk("t6_rd_miss_hi", rd_data, 32'h0);
        iobus_addr = 32'h0000_0004;
        #1;
        chk("t6_rd_miss_lo", rd_data, 32'h0);
        iobus_addr = '0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
